mux_delay_line: RTL and testbench

// - Parametrised source-select + delay line: N_SRC-way input mux feeding a DEPTH-stage,

---
 rtl/mux_delay_line_pkg.sv | 19 +
 rtl/mux_delay_line_if.sv | 41 ++++
 rtl/mux_delay_line_pipe_stage.sv | 51 +++++
 rtl/mux_delay_line.sv | 97 +++++++++
 tb/tb_mux_delay_line.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mux_delay_line_pkg.sv
// Shared constants for the AES-aligned mux + delay line.
//   DEF_WIDTH/DEF_DEPTH/DEF_N_SRC : default build parameters
//   MODE_SHIFT/MODE_ROTATE        : encodings of the mode input
//   tap_width()                   : width of the tap selector for a given depth
package mux_delay_line_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_N_SRC = 2;

  localparam logic MODE_SHIFT  = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

  // A single-stage line still needs a 1-bit tap selector.
  function automatic int unsigned tap_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mux_delay_line_if.sv
// Bus bundle for mux_delay_line: source data/select, pipeline controls and
// the observation outputs.
//   master : drives in_data, sel, in_valid, en, flush, mode, tap_sel
//   slave  : drives q, q_valid, tap_q, tap_valid, count
interface mux_delay_line_if
  import mux_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned N_SRC = DEF_N_SRC
) ();

  localparam int unsigned SEL_W = $clog2(N_SRC);
  localparam int unsigned TAP_W = tap_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [N_SRC*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]       sel;
  logic                   in_valid;
  logic                   en;
  logic                   flush;
  logic                   mode;
  logic [TAP_W-1:0]       tap_sel;

  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [WIDTH-1:0]       tap_q;
  logic                   tap_valid;
  logic [CNT_W-1:0]       count;

  modport master (
    output in_data, sel, in_valid, en, flush, mode, tap_sel,
    input  q, q_valid, tap_q, tap_valid, count
  );

  modport slave (
    input  in_data, sel, in_valid, en, flush, mode, tap_sel,
    output q, q_valid, tap_q, tap_valid, count
  );

endinterface

// File: rtl/mux_delay_line_pipe_stage.sv
// One delay-line stage: data + valid register with synchronous flush and
// clock enable; flush wins over enable.
//   clk, rst_n         : clock, async active-low reset
//   en_i, flush_i      : advance / clear
//   data_i, valid_i    : next-stage payload
//   data_o, valid_o    : registered payload
module pipe_stage
  import mux_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next-state: flush > en > hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (en_i) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/mux_delay_line.sv
// N_SRC-way source mux feeding a DEPTH-stage delay line with per-stage
// valid, stall, flush and rotate; used to align byte/word streams with the
// AES datapath latency.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of mux_delay_line_if (inputs, q/q_valid from the
//              last stage, combinational tap read, registered valid count)
module mux_delay_line
  import mux_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned N_SRC = DEF_N_SRC
) (
  input  logic             clk,
  input  logic             rst,
  mux_delay_line_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] stage_data     [DEPTH];
  logic             stage_valid    [DEPTH];
  logic [WIDTH-1:0] stage_in_data  [DEPTH];
  logic             stage_in_valid [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Source select; out-of-range selects (non-power-of-2 N_SRC) yield zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (int'(bus.sel) == k) begin
        mux_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage chain; stage 0 takes either the mux or the last stage (rotate).
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_in_data[i]  = (bus.mode == MODE_ROTATE) ? stage_data[DEPTH-1]  : mux_data;
      assign stage_in_valid[i] = (bus.mode == MODE_ROTATE) ? stage_valid[DEPTH-1] : bus.in_valid;
    end else begin : g_body
      assign stage_in_data[i]  = stage_data[i-1];
      assign stage_in_valid[i] = stage_valid[i-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst),
      .en_i    (bus.en),
      .flush_i (bus.flush),
      .data_i  (stage_in_data[i]),
      .valid_i (stage_in_valid[i]),
      .data_o  (stage_data[i]),
      .valid_o (stage_valid[i])
    );
  end

  // Valid-stage count: one in, one out per shift; rotate keeps the set.
  // Bounded by construction: a full line always retires its last stage.
  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else if (bus.en && (bus.mode == MODE_SHIFT)) begin
      count_d = count_q + CNT_W'(bus.in_valid) - CNT_W'(stage_valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Tap read; selectors beyond the last stage read as empty.
  always_comb begin
    bus.tap_q     = '0;
    bus.tap_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (int'(bus.tap_sel) == i) begin
        bus.tap_q     = stage_data[i];
        bus.tap_valid = stage_valid[i];
      end
    end
  end

  assign bus.q       = stage_data[DEPTH-1];
  assign bus.q_valid = stage_valid[DEPTH-1];
  assign bus.count   = count_q;

endmodule

// File: tb/tb_mux_delay_line.sv
// Directed bench for mux_delay_line: default build (8/4/2) plus an 8/5/3
// build for the out-of-range select and tap cases.
module tb_mux_delay_line;
  import mux_delay_line_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_delay_line_if #(.WIDTH(8), .DEPTH(4), .N_SRC(2)) bus_a ();
  mux_delay_line_if #(.WIDTH(8), .DEPTH(5), .N_SRC(3)) bus_b ();

  mux_delay_line #(.WIDTH(8), .DEPTH(4), .N_SRC(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mux_delay_line #(.WIDTH(8), .DEPTH(5), .N_SRC(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] shift_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] fill_b  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rot_b   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] rot_q   [4] = '{8'h02, 8'h03, 8'h04, 8'h01};
  logic       pv      [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] pc      [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd2, 3'd2};
  logic       pq      [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [15:0] data, input logic sel, input logic valid,
                         input logic en, input logic flush, input logic mode);
    bus_a.in_data  = data;
    bus_a.sel      = sel;
    bus_a.in_valid = valid;
    bus_a.en       = en;
    bus_a.flush    = flush;
    bus_a.mode     = mode;
  endtask

  initial begin
    rst = 1'b0;
    drive_a(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, MODE_SHIFT);
    bus_a.tap_sel  = '0;
    bus_b.in_data  = '0;
    bus_b.sel      = '0;
    bus_b.in_valid = 1'b0;
    bus_b.en       = 1'b0;
    bus_b.flush    = 1'b0;
    bus_b.mode     = MODE_SHIFT;
    bus_b.tap_sel  = '0;

    tick();
    tick();
    check("rst_q",       32'(bus_a.q), 32'h0);
    check("rst_q_valid", 32'(bus_a.q_valid), 32'h0);
    check("rst_count",   32'(bus_a.count), 32'h0);
    check("rst_tap_q",   32'(bus_a.tap_q), 32'h0);
    check("rst_b_count", 32'(bus_b.count), 32'h0);
    rst = 1'b1;

    // Shift from source 1.
    for (int i = 0; i < 4; i++) begin
      drive_a({shift_b[i], 8'h5A}, 1'b1, 1'b1, 1'b1, 1'b0, MODE_SHIFT);
      tick();
    end
    check("shift_q",       32'(bus_a.q), 32'hA1);
    check("shift_q_valid", 32'(bus_a.q_valid), 32'h1);
    check("shift_count",   32'(bus_a.count), 32'h4);
    bus_a.tap_sel = 2'd0;
    #1 check("shift_tap0", 32'(bus_a.tap_q), 32'hD4);
    bus_a.tap_sel = 2'd2;
    #1 check("shift_tap2", 32'(bus_a.tap_q), 32'hB2);

    // Asynchronous reset with a full line, between clock edges.
    drive_a(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, MODE_SHIFT);
    #1 rst = 1'b0;
    #1;
    check("arst_q",       32'(bus_a.q), 32'h0);
    check("arst_q_valid", 32'(bus_a.q_valid), 32'h0);
    check("arst_count",   32'(bus_a.count), 32'h0);
    check("arst_tap_q",   32'(bus_a.tap_q), 32'h0);
    #1 rst = 1'b1;

    // Fill, then stall with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      drive_a({fill_b[i], 8'h00}, 1'b1, 1'b1, 1'b1, 1'b0, MODE_SHIFT);
      tick();
    end
    check("fill_q", 32'(bus_a.q), 32'h11);
    for (int i = 0; i < 3; i++) begin
      drive_a(16'($urandom), 1'(i), 1'(i), 1'b0, 1'b0, 1'(i));
      tick();
      check("stall_q",     32'(bus_a.q), 32'h11);
      check("stall_count", 32'(bus_a.count), 32'h4);
    end
    drive_a(16'h5500, 1'b1, 1'b1, 1'b1, 1'b0, MODE_SHIFT);
    tick();
    check("resume_q",     32'(bus_a.q), 32'h22);
    check("resume_count", 32'(bus_a.count), 32'h4);

    // Rotate a 01..04 line.
    for (int i = 0; i < 4; i++) begin
      drive_a({rot_b[i], 8'h00}, 1'b1, 1'b1, 1'b1, 1'b0, MODE_SHIFT);
      tick();
    end
    check("rot_pre_q", 32'(bus_a.q), 32'h01);
    for (int i = 0; i < 4; i++) begin
      drive_a(16'hEEEE, 1'b1, 1'b0, 1'b1, 1'b0, MODE_ROTATE);
      tick();
      check("rot_q",     32'(bus_a.q), 32'(rot_q[i]));
      check("rot_count", 32'(bus_a.count), 32'h4);
    end
    bus_a.tap_sel = 2'd0;
    #1 check("rot_tap0", 32'(bus_a.tap_q), 32'h04);

    // Flush beats enable.
    drive_a(16'h7777, 1'b1, 1'b1, 1'b1, 1'b1, MODE_SHIFT);
    tick();
    check("flush_count",     32'(bus_a.count), 32'h0);
    check("flush_q_valid",   32'(bus_a.q_valid), 32'h0);
    check("flush_q",         32'(bus_a.q), 32'h0);
    check("flush_tap_valid", 32'(bus_a.tap_valid), 32'h0);

    // Alternating valid from source 0; count follows the valid popcount.
    for (int i = 0; i < 8; i++) begin
      drive_a({8'hFF, 8'(8'h61 + i)}, 1'b0, pv[i], 1'b1, 1'b0, MODE_SHIFT);
      tick();
      check("pop_count",   32'(bus_a.count), 32'(pc[i]));
      check("pop_q_valid", 32'(bus_a.q_valid), 32'(pq[i]));
      if (i == 3) check("pop_q", 32'(bus_a.q), 32'h61);
    end
    drive_a(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, MODE_SHIFT);

    // Three-source build: out-of-range select and tap.
    bus_b.in_data  = {8'hCC, 8'hBB, 8'hAA};
    bus_b.sel      = 2'd3;
    bus_b.in_valid = 1'b1;
    bus_b.en       = 1'b1;
    tick();
    bus_b.tap_sel = 3'd0;
    #1;
    check("b_sel3_tap_q",     32'(bus_b.tap_q), 32'h00);
    check("b_sel3_tap_valid", 32'(bus_b.tap_valid), 32'h1);
    check("b_sel3_count",     32'(bus_b.count), 32'h1);
    bus_b.sel = 2'd2;
    tick();
    bus_b.sel = 2'd1;
    tick();
    bus_b.en = 1'b0;
    bus_b.tap_sel = 3'd1;
    #1 check("b_sel2_tap1", 32'(bus_b.tap_q), 32'hCC);
    bus_b.tap_sel = 3'd0;
    #1 check("b_sel1_tap0", 32'(bus_b.tap_q), 32'hBB);
    bus_b.tap_sel = 3'd2;
    #1 check("b_sel3_tap2", 32'(bus_b.tap_q), 32'h00);
    check("b_count3", 32'(bus_b.count), 32'h3);
    bus_b.tap_sel = 3'd5;
    #1;
    check("b_tap5_q",     32'(bus_b.tap_q), 32'h00);
    check("b_tap5_valid", 32'(bus_b.tap_valid), 32'h0);
    bus_b.tap_sel = 3'd7;
    #1;
    check("b_tap7_q",     32'(bus_b.tap_q), 32'h00);
    check("b_tap7_valid", 32'(bus_b.tap_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
